// File: rtl/riscv_fetch_unit.sv
// Instruction fetch unit: issues sequential fetches into a small instruction
// buffer, presents the buffer head to decode, and flushes/refetches on redirect.
module riscv_fetch_unit #(
   parameter int unsigned DEPTH     = 4,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   output logic        out_valid,
   output logic [31:0] out_instr,
   output logic [31:0] out_addr,
   input  logic        out_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_addr
);

   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [31:0]     pc_q, pc_d;
   logic            inflight_q, inflight_d;
   logic [31:0]     inflight_addr_q, inflight_addr_d;
   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic [31:0]     instr_q [DEPTH];
   logic [31:0]     addr_q  [DEPTH];

   logic            push;
   logic            pop;
   logic [CntW-1:0] occupancy;

   // Request gating, push/pop decode and head-of-buffer presentation
   always_comb begin
      occupancy = count_q + CntW'(inflight_q);
      // rst_n gating keeps the request low while held in reset
      imem_req  = rst_n && !redirect && (occupancy < CntW'(DEPTH));
      imem_addr = pc_q;
      out_valid = (count_q != '0);
      out_instr = out_valid ? instr_q[rd_ptr_q] : NOP_INSTR;
      out_addr  = out_valid ? addr_q[rd_ptr_q] : 32'h0;
      // A redirect kills the in-flight response and blocks the pop
      push      = inflight_q && !redirect;
      pop       = out_valid && out_ready && !redirect;
   end

   // Next-state for PC, in-flight tracking, pointers and occupancy
   always_comb begin
      pc_d            = pc_q;
      inflight_d      = imem_req;
      inflight_addr_d = inflight_addr_q;
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      count_d         = count_q;
      if (redirect) begin
         pc_d     = redirect_addr & 32'hFFFF_FFFC;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (imem_req) begin
            pc_d            = pc_q + 32'd4;
            inflight_addr_d = pc_q;
         end
         if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(push) - CntW'(pop);
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q            <= RESET_PC & 32'hFFFF_FFFC;
         inflight_q      <= 1'b0;
         inflight_addr_q <= 32'h0;
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         count_q         <= '0;
      end else begin
         pc_q            <= pc_d;
         inflight_q      <= inflight_d;
         inflight_addr_q <= inflight_addr_d;
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         count_q         <= count_d;
      end
   end

   // Buffer storage: response and its request address written at the tail
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_q[i] <= 32'h0;
            addr_q[i]  <= 32'h0;
         end
      end else if (push) begin
         instr_q[wr_ptr_q] <= imem_rdata;
         addr_q[wr_ptr_q]  <= inflight_addr_q;
      end
   end

   // Request gating must make a push into a full buffer unreachable
   overflow_a : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && (count_q == CntW'(DEPTH))));

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Self-checking bench for riscv_fetch_unit: scoreboard of expected fetch
// order popped whenever decode accepts an entry, plus directed timing checks.
module tb_riscv_fetch_unit;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_addr;
   logic        out_ready;
   logic        redirect;
   logic [31:0] redirect_addr;

   // Second instance exercises address wrap from a high reset PC
   logic        rst2_n;
   logic        imem2_req;
   logic [31:0] imem2_addr;
   logic [31:0] imem2_rdata;
   logic        out2_valid;
   logic [31:0] out2_instr;
   logic [31:0] out2_addr;

   int n_checks = 0;
   int n_fail   = 0;
   int pops     = 0;
   int pops2    = 0;
   int reqs     = 0;
   int pops_base;
   logic [31:0] sb_q  [$];
   logic [31:0] sb2_q [$];

   riscv_fetch_unit #(
      .DEPTH     (4),
      .RESET_PC  (32'h0000_0000),
      .NOP_INSTR (32'h0000_0013)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_rdata    (imem_rdata),
      .out_valid     (out_valid),
      .out_instr     (out_instr),
      .out_addr      (out_addr),
      .out_ready     (out_ready),
      .redirect      (redirect),
      .redirect_addr (redirect_addr)
   );

   riscv_fetch_unit #(
      .DEPTH     (4),
      .RESET_PC  (32'hFFFF_FFF8),
      .NOP_INSTR (32'h0000_0013)
   ) dut_wrap (
      .clk           (clk),
      .rst_n         (rst2_n),
      .imem_req      (imem2_req),
      .imem_addr     (imem2_addr),
      .imem_rdata    (imem2_rdata),
      .out_valid     (out2_valid),
      .out_instr     (out2_instr),
      .out_addr      (out2_addr),
      .out_ready     (1'b1),
      .redirect      (1'b0),
      .redirect_addr (32'h0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a fixed scramble of the address
   function automatic logic [31:0] mem_data(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_load(input logic [31:0] base);
      sb_q.delete();
      for (int i = 0; i < 64; i++) sb_q.push_back(base + 32'(i) * 32'd4);
   endtask

   // Instruction memory models: data one cycle after the request
   always @(posedge clk) imem_rdata  <= imem_req  ? mem_data(imem_addr)  : 32'hDEAD_BEEF;
   always @(posedge clk) imem2_rdata <= imem2_req ? mem_data(imem2_addr) : 32'hDEAD_BEEF;

   // Scoreboard: every accepted head entry must be the next expected fetch
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready && !redirect) begin
         if (sb_q.size() == 0) begin
            check("sb_underrun", out_addr, 32'hFFFF_FFFF);
         end else begin
            logic [31:0] e;
            e = sb_q.pop_front();
            check("pop_addr", out_addr, e);
            check("pop_instr", out_instr, mem_data(e));
            pops++;
         end
      end
   end

   always @(negedge clk) begin
      if (rst2_n && out2_valid && sb2_q.size() != 0) begin
         logic [31:0] e;
         e = sb2_q.pop_front();
         check("wrap_addr", out2_addr, e);
         check("wrap_instr", out2_instr, mem_data(e));
         pops2++;
      end
   end

   initial begin
      rst_n = 1'b0; rst2_n = 1'b0; out_ready = 1'b0; redirect = 1'b0; redirect_addr = 32'h0;
      for (int i = 0; i < 300; i++) sb2_q.push_back(32'hFFFF_FFF8 + 32'(i) * 32'd4);
      #12;
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_instr", out_instr, 32'h0000_0013);
      check("rst_addr", out_addr, 32'h0);

      // Streaming
      step();
      sb_load(32'h0);
      out_ready = 1'b1;
      rst_n = 1'b1; rst2_n = 1'b1;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (c == 0) begin
            check("first_req", 32'(imem_req), 32'd1);
            check("first_req_addr", imem_addr, 32'h0);
         end
         check("stream_valid", 32'(out_valid), (c >= 2) ? 32'd1 : 32'd0);
         if (c == 2) check("stream_first_addr", out_addr, 32'h0);
         step();
      end
      check("stream_pops", 32'(pops), 32'd12);

      // Asynchronous reset between edges
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      #1;
      check("arst_req", 32'(imem_req), 32'd0);
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_instr", out_instr, 32'h0000_0013);
      check("arst_addr", out_addr, 32'h0);

      // Backpressure
      out_ready = 1'b0;
      step();
      pops = 0;
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (imem_req) begin
            check("bp_req_addr", imem_addr, 32'(reqs) * 32'd4);
            reqs++;
         end
         if (c >= 2) begin
            check("bp_hold_addr", out_addr, 32'h0);
            check("bp_hold_instr", out_instr, mem_data(32'h0));
         end
         step();
      end
      check("bp_req_count", 32'(reqs), 32'd4);
      check("bp_full_noreq", 32'(imem_req), 32'd0);
      sb_load(32'h0);
      out_ready = 1'b1;
      for (int c = 0; c < 8; c++) step();
      check("bp_drain_pops", 32'(pops), 32'd8);

      // Redirect with 3 entries buffered and 1 in flight
      rst_n = 1'b0;
      sb_q.delete();
      out_ready = 1'b0;
      step();
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) step();
      redirect = 1'b1;
      redirect_addr = 32'h0000_0103;
      sb_load(32'h100);
      @(negedge clk);
      check("rd_noreq", 32'(imem_req), 32'd0);
      step();
      redirect = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("rd_valid_clr", 32'(out_valid), 32'd0);
      check("rd_addr", imem_addr, 32'h0000_0100);
      check("rd_req", 32'(imem_req), 32'd1);
      step();
      @(negedge clk);
      check("rd_lat_valid", 32'(out_valid), 32'd0);
      step();
      @(negedge clk);
      check("rd_out_valid", 32'(out_valid), 32'd1);
      check("rd_out_addr", out_addr, 32'h0000_0100);
      for (int c = 0; c < 4; c++) step();

      // Redirect together with a pop
      @(negedge clk);
      check("rp_pre_valid", 32'(out_valid), 32'd1);
      step();
      redirect = 1'b1;
      redirect_addr = 32'h0000_0200;
      sb_load(32'h200);
      step();
      redirect = 1'b0;
      @(negedge clk);
      check("rp_empty", 32'(out_valid), 32'd0);
      check("rp_addr", imem_addr, 32'h0000_0200);
      step();
      step();
      @(negedge clk);
      check("rp_out_addr", out_addr, 32'h0000_0200);
      for (int c = 0; c < 4; c++) step();

      // Back-to-back redirects: only the last target is fetched
      redirect = 1'b1;
      redirect_addr = 32'h0000_0300;
      step();
      redirect_addr = 32'h0000_0400;
      sb_load(32'h400);
      @(negedge clk);
      check("b2b_noreq", 32'(imem_req), 32'd0);
      step();
      redirect = 1'b0;
      pops_base = pops;
      @(negedge clk);
      check("b2b_addr", imem_addr, 32'h0000_0400);
      for (int c = 0; c < 6; c++) step();
      check("b2b_pops", 32'(pops - pops_base), 32'd4);

      check("wrap_progress", 32'(pops2 > 40), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
